tick_sched: RTL and testbench

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched_pkg.sv | 20 ++
 rtl/tick_sched_if.sv | 33 +++
 rtl/tick_sched_chan.sv | 56 +++++
 rtl/tick_sched.sv | 110 +++++++++++
 tb/tb_tick_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg -- shared definitions for the tick scheduler slice.
//   cfg_state_t  : configuration FSM state encoding (IDLE, APPLY)
//   *_DEF        : default values for the NCH, PRESCALE and PW parameters
//   chw()        : index width for n channels (at least 1 bit)
package tick_sched_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_APPLY = 1'b1
   } cfg_state_t;

   localparam int unsigned NCH_DEF      = 4;
   localparam int unsigned PRESCALE_DEF = 50;
   localparam int unsigned PW_DEF       = 16;

   function automatic int unsigned chw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_sched_if.sv
// tick_sched_if -- configuration request bus of tick_sched.
//   cfg_valid  : request valid (master -> slave)
//   cfg_ready  : slave can accept a request (slave -> master)
//   cfg_ch     : target channel index
//   cfg_period : channel period in base ticks
//   cfg_en     : channel enable value to write
//   cfg_err    : one-cycle pulse when a write is rejected as illegal
interface tick_sched_if
   import tick_sched_pkg::*;
#(
   parameter int unsigned NCH = NCH_DEF,
   parameter int unsigned PW  = PW_DEF
);
   localparam int unsigned CHW = chw(NCH);

   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [PW-1:0]  cfg_period;
   logic           cfg_en;
   logic           cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_en,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_en,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/tick_sched_chan.sv
// tick_sched_chan -- one tick channel: period counter, compare, tick, toggle.
//   clkin      : clock (posedge)
//   rst        : asynchronous active-high reset
//   base_tick  : one-cycle strobe from the shared prescaler
//   wr         : write strobe from the config FSM (APPLY on this channel)
//   wr_period  : period to store on wr
//   wr_en      : enable to store on wr
//   tick_out   : one-cycle pulse on period expiry
//   clk_out    : square wave toggling on each tick
//   ch_en      : current enable state
module tick_sched_chan #(
   parameter int unsigned PW = 16
) (
   input  logic          clkin,
   input  logic          rst,
   input  logic          base_tick,
   input  logic          wr,
   input  logic [PW-1:0] wr_period,
   input  logic          wr_en,
   output logic          tick_out,
   output logic          clk_out,
   output logic          ch_en
);

   logic [PW-1:0] period;
   logic [PW-1:0] cnt;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         period   <= '0;
         cnt      <= '0;
         ch_en    <= 1'b0;
         tick_out <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         tick_out <= 1'b0;
         // A write wins over a coinciding base tick: counter restarts, no tick.
         if (wr) begin
            period  <= wr_period;
            ch_en   <= wr_en;
            cnt     <= '0;
            clk_out <= 1'b0;
         end else if (ch_en && base_tick) begin
            // period is never 0 while enabled; illegal writes disable the channel
            if (cnt == period - PW'(1)) begin
               cnt      <= '0;
               tick_out <= 1'b1;
               clk_out  <= ~clk_out;
            end else begin
               cnt <= cnt + PW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/tick_sched.sv
// tick_sched -- multi-channel periodic tick generator.
//   clkin    : clock (posedge)
//   rst      : asynchronous active-high reset
//   cfg      : configuration bus (slave side), see tick_sched_if
//   tick_out : per-channel one-cycle pulse on period expiry
//   clk_out  : per-channel square wave toggling on each tick
//   ch_en    : per-channel enable state
// A shared prescaler produces base_tick every PRESCALE cycles; a two-state
// config FSM latches a request in IDLE and writes it to one channel in APPLY.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int unsigned NCH      = NCH_DEF,
   parameter int unsigned PRESCALE = PRESCALE_DEF,
   parameter int unsigned PW       = PW_DEF
) (
   input  logic           clkin,
   input  logic           rst,
   tick_sched_if.slave    cfg,
   output logic [NCH-1:0] tick_out,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] ch_en
);

   localparam int unsigned CHW = chw(NCH);
   localparam int unsigned PSW = $clog2(PRESCALE);

   // ---------------- prescaler ----------------
   logic [PSW-1:0] pcnt;
   logic           base_tick;

   assign base_tick = (pcnt == PSW'(PRESCALE - 1));

   always_ff @(posedge clkin or posedge rst) begin
      if (rst)            pcnt <= '0;
      else if (base_tick) pcnt <= '0;
      else                pcnt <= pcnt + PSW'(1);
   end

   // ---------------- config FSM ----------------
   cfg_state_t     state, state_nx;
   logic           accept;
   logic           bad_ch;
   logic           bad_period;
   logic [CHW-1:0] ch_q;
   logic [PW-1:0]  period_q;
   logic           en_q;
   logic           ch_ok_q;

   assign bad_ch     = (32'(cfg.cfg_ch) >= NCH);
   assign bad_period = cfg.cfg_en && (cfg.cfg_period == '0);

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg.cfg_valid && cfg.cfg_ready) begin
               accept   = 1'b1;
               state_nx = ST_APPLY;
            end
         end
         ST_APPLY: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // cfg_ready and cfg_err are registered from the next state / accepted
   // request so that they are valid during IDLE / the APPLY cycle respectively.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         cfg.cfg_ready <= 1'b0;
         cfg.cfg_err   <= 1'b0;
         ch_q          <= '0;
         period_q      <= '0;
         en_q          <= 1'b0;
         ch_ok_q       <= 1'b0;
      end else begin
         state         <= state_nx;
         cfg.cfg_ready <= (state_nx == ST_IDLE);
         cfg.cfg_err   <= accept && (bad_ch || bad_period);
         if (accept) begin
            ch_q     <= cfg.cfg_ch;
            period_q <= cfg.cfg_period;
            en_q     <= cfg.cfg_en && !bad_period;
            ch_ok_q  <= !bad_ch;
         end
      end
   end

   // ---------------- channels ----------------
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic wr;
      assign wr = (state == ST_APPLY) && ch_ok_q && (ch_q == CHW'(i));

      tick_sched_chan #(.PW(PW)) u_chan (
         .clkin     (clkin),
         .rst       (rst),
         .base_tick (base_tick),
         .wr        (wr),
         .wr_period (period_q),
         .wr_en     (en_q),
         .tick_out  (tick_out[i]),
         .clk_out   (clk_out[i]),
         .ch_en     (ch_en[i])
      );
   end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched -- directed bench for tick_sched with NCH=3, PRESCALE=4, PW=16.
// Edge numbering: E1 is the first clkin rising edge after rst is released;
// with PRESCALE=4 the base tick edges are E4, E8, E12, ...
module tb_tick_sched;

   localparam int unsigned NCH      = 3;
   localparam int unsigned PRESCALE = 4;
   localparam int unsigned PW       = 16;

   logic           clkin;
   logic           rst;
   logic [NCH-1:0] tick_out;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] ch_en;

   tick_sched_if #(.NCH(NCH), .PW(PW)) cfg_bus ();

   tick_sched #(.NCH(NCH), .PRESCALE(PRESCALE), .PW(PW)) dut (
      .clkin    (clkin),
      .rst      (rst),
      .cfg      (cfg_bus),
      .tick_out (tick_out),
      .clk_out  (clk_out),
      .ch_en    (ch_en)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   int npass;
   int ntot;
   int ecnt;
   bit rec;
   bit clk0_prev;
   int tk0[$];
   int rise0[$];
   int tk1_cnt;
   int clk1_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (edge E%0d)", tag, got, exp, ecnt);
   endtask

   // advance one rising edge and sample 1 ns later
   task automatic step();
      @(posedge clkin);
      #1;
      ecnt++;
      if (rec) begin
         if (tick_out[0]) tk0.push_back(ecnt);
         if (clk_out[0] && !clk0_prev) rise0.push_back(ecnt);
         clk0_prev = clk_out[0];
         if (tick_out[1]) tk1_cnt++;
         if (clk_out[1])  clk1_cnt++;
      end
   endtask

   task automatic req(input int ch, input int period, input bit en, input bit valid);
      cfg_bus.cfg_ch     = 2'(ch);
      cfg_bus.cfg_period = 16'(period);
      cfg_bus.cfg_en     = en;
      cfg_bus.cfg_valid  = valid;
   endtask

   initial begin
      npass = 0; ntot = 0; ecnt = 0; rec = 1'b0; clk0_prev = 1'b0;
      tk1_cnt = 0; clk1_cnt = 0;
      req(0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_ready",   32'(cfg_bus.cfg_ready), 32'd0);
      chk("rst_err",     32'(cfg_bus.cfg_err),   32'd0);
      chk("rst_tick",    32'(tick_out), 32'd0);
      chk("rst_clk",     32'(clk_out),  32'd0);
      chk("rst_chen",    32'(ch_en),    32'd0);
      #9 rst = 1'b0;
      #1 chk("ready_pre_edge", 32'(cfg_bus.cfg_ready), 32'd0);

      step(); // E1
      chk("ready_e1", 32'(cfg_bus.cfg_ready), 32'd1);
      chk("chen_e1",  32'(ch_en),    32'd0);
      chk("tick_e1",  32'(tick_out), 32'd0);
      chk("clk_e1",   32'(clk_out),  32'd0);

      // ch0 period 3 enabled: accept E2, applied E3
      req(0, 3, 1'b1, 1'b1);
      step(); // E2
      chk("ready_apply", 32'(cfg_bus.cfg_ready), 32'd0);
      chk("err_ok",      32'(cfg_bus.cfg_err),   32'd0);
      chk("chen_pending", 32'(ch_en), 32'd0);
      cfg_bus.cfg_valid = 1'b0;
      step(); // E3
      chk("chen_ch0", 32'(ch_en), 32'b001);
      chk("ready_back", 32'(cfg_bus.cfg_ready), 32'd1);

      // ch1 period 0 enabled is illegal
      req(1, 0, 1'b1, 1'b1);
      step(); // E4
      chk("err_p0_pulse", 32'(cfg_bus.cfg_err), 32'd1);
      cfg_bus.cfg_valid = 1'b0;
      step(); // E5
      chk("err_p0_clear", 32'(cfg_bus.cfg_err), 32'd0);
      chk("chen_p0", 32'(ch_en), 32'b001);

      rec = 1'b1;
      repeat (35) step(); // E40
      rec = 1'b0;
      chk("tk0_count", 32'(tk0.size()), 32'd3);
      chk("tk0_first", 32'(tk0[0]), 32'd12);
      chk("tk0_second", 32'(tk0[1]), 32'd24);
      chk("tk0_third", 32'(tk0[2]), 32'd36);
      chk("clk0_rises", 32'(rise0.size()), 32'd2);
      chk("clk0_period", 32'(rise0[1] - rise0[0]), 32'd24);
      chk("ch1_no_tick", 32'(tk1_cnt), 32'd0);
      chk("ch1_no_clk",  32'(clk1_cnt), 32'd0);
      chk("clk_e40", 32'(clk_out), 32'b001);

      // valid held 4 cycles: A accepted E41, B ignored, C accepted E43, D ignored
      req(2, 2, 1'b1, 1'b1);
      step(); // E41
      chk("b2b_ready_e41", 32'(cfg_bus.cfg_ready), 32'd0);
      req(1, 5, 1'b1, 1'b1);
      step(); // E42
      chk("b2b_ready_e42", 32'(cfg_bus.cfg_ready), 32'd1);
      req(1, 1, 1'b1, 1'b1);
      step(); // E43
      chk("b2b_ready_e43", 32'(cfg_bus.cfg_ready), 32'd0);
      req(2, 7, 1'b0, 1'b1);
      step(); // E44: ch1 write coincides with base tick
      cfg_bus.cfg_valid = 1'b0;
      chk("b2b_ready_e44", 32'(cfg_bus.cfg_ready), 32'd1);
      chk("b2b_chen", 32'(ch_en), 32'b111);
      chk("tick_e44", 32'(tick_out), 32'b000);
      repeat (4) step(); // E48
      chk("tick_e48", 32'(tick_out), 32'b111);

      // rewrite ch0 so the apply lands on its expiring base tick (E60)
      repeat (10) step(); // E58
      req(0, 3, 1'b1, 1'b1);
      step(); // E59
      chk("rew_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      cfg_bus.cfg_valid = 1'b0;
      step(); // E60
      chk("rew_tick_e60", 32'(tick_out), 32'b010);
      chk("rew_clk_e60",  32'(clk_out),  32'b000);
      repeat (4) step(); // E64
      chk("rew_tick_e64", 32'(tick_out), 32'b110);
      repeat (8) step(); // E72
      chk("rew_tick_e72", 32'(tick_out), 32'b111);

      // channel index 3 does not exist
      req(3, 5, 1'b1, 1'b1);
      step(); // E73
      chk("badch_err", 32'(cfg_bus.cfg_err), 32'd1);
      cfg_bus.cfg_valid = 1'b0;
      step(); // E74
      chk("badch_err_clear", 32'(cfg_bus.cfg_err), 32'd0);
      chk("badch_chen", 32'(ch_en), 32'b111);

      // period 0 with en 0 is a legal disable
      req(1, 0, 1'b0, 1'b1);
      step(); // E75
      chk("dis_err", 32'(cfg_bus.cfg_err), 32'd0);
      cfg_bus.cfg_valid = 1'b0;
      step(); // E76
      chk("dis_chen", 32'(ch_en), 32'b101);
      chk("dis_clk",  32'(clk_out), 32'b001);

      // reset arrives while a ch1 enable is in APPLY
      req(1, 1, 1'b1, 1'b1);
      step(); // E77
      cfg_bus.cfg_valid = 1'b0;
      chk("pre_rst_chen", 32'(ch_en), 32'b101);
      #2 rst = 1'b1;
      #1;
      chk("async_tick",  32'(tick_out), 32'd0);
      chk("async_clk",   32'(clk_out),  32'd0);
      chk("async_chen",  32'(ch_en),    32'd0);
      chk("async_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      chk("async_err",   32'(cfg_bus.cfg_err),   32'd0);
      step();
      chk("hold_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      #3 rst = 1'b0;
      step();
      chk("rel_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      chk("rel_chen",  32'(ch_en), 32'd0);
      repeat (8) step();
      chk("rel_chen_late", 32'(ch_en),    32'd0);
      chk("rel_tick_late", 32'(tick_out), 32'd0);
      chk("rel_clk_late",  32'(clk_out),  32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
